// File: rtl/uart_packet_deframer_if.sv
// rtl/uart_packet_deframer_if.sv - Rx byte strobe and UART_PACKET beat bundle for uart_packet_deframer
interface uart_packet_deframer_if;
    typedef struct packed {
        logic [7:0] Source;
        logic [7:0] Destination;
        logic [7:0] Length;
        logic       SoP;
        logic       EoP;
        logic [7:0] Data;
        logic       Valid;
    } uart_packet_t;

    logic [7:0]   ipRxData;
    logic         ipRxValid;
    uart_packet_t opPacket;

    modport master (output ipRxData, output ipRxValid, input opPacket);
    modport slave  (input ipRxData, input ipRxValid, output opPacket);
endinterface

// File: rtl/uart_packet_deframer.sv
// rtl/uart_packet_deframer.sv - UART byte stream to UART_PACKET beats; optional trailing checksum via CHECKSUM_EN
module uart_packet_deframer #(
    parameter logic [7:0] SYNC_BYTE      = 8'h55,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic                   ipClk,
    input  logic                   reset,
    uart_packet_deframer_if.slave  bus,
    output logic                   opPacketDone,
    output logic                   opTimeout,
    output logic                   opChecksumError
);
    typedef enum logic [2:0] {
        IDLE,
        GET_DEST,
        GET_SOURCE,
        GET_LENGTH,
        GET_DATA
`ifdef CHECKSUM_EN
        , GET_CHECKSUM
`endif
    } state_t;

    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_dest;
    logic [7:0]  r_src;
    logic [7:0]  r_len;
    logic        r_valid;
    logic        r_sop;
    logic        r_eop;
    logic [7:0]  r_data;
    logic [8:0]  r_remaining;
    logic        r_first;
    logic [19:0] r_tcount;
    logic        r_done;
    logic        r_timeout;
    logic        w_byte;
    logic        w_expire;
    logic        w_last;

    assign w_byte   = bus.ipRxValid;
    // A byte arriving on the expiry cycle keeps the frame alive.
    assign w_expire = (r_state != IDLE) && !w_byte && (r_tcount == TIMEOUT_LAST);
    assign w_last   = (r_remaining == 9'd0);

    always_ff @(posedge ipClk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_expire) begin
            w_next = IDLE;
        end else if (w_byte) begin
            case (r_state)
                IDLE:       if (bus.ipRxData == SYNC_BYTE) w_next = GET_DEST;
                GET_DEST:   w_next = GET_SOURCE;
                GET_SOURCE: w_next = GET_LENGTH;
                GET_LENGTH: w_next = GET_DATA;
`ifdef CHECKSUM_EN
                GET_DATA:     if (w_last) w_next = GET_CHECKSUM;
                GET_CHECKSUM: w_next = IDLE;
`else
                GET_DATA:   if (w_last) w_next = IDLE;
`endif
                default:    w_next = IDLE;
            endcase
        end
    end

`ifdef CHECKSUM_EN
    logic [7:0] r_sum;
    logic       r_cs_err;
`endif

    always_ff @(posedge ipClk) begin
        if (reset) begin
            r_dest      <= 8'd0;
            r_src       <= 8'd0;
            r_len       <= 8'd0;
            r_valid     <= 1'b0;
            r_sop       <= 1'b0;
            r_eop       <= 1'b0;
            r_data      <= 8'd0;
            r_remaining <= 9'd0;
            r_first     <= 1'b0;
            r_tcount    <= 20'd0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
`ifdef CHECKSUM_EN
            r_sum       <= 8'd0;
            r_cs_err    <= 1'b0;
`endif
        end else begin
            r_valid   <= 1'b0;
            r_sop     <= 1'b0;
            r_eop     <= 1'b0;
            r_data    <= 8'd0;
            r_done    <= 1'b0;
            r_timeout <= w_expire;
`ifdef CHECKSUM_EN
            r_cs_err  <= 1'b0;
`endif
            if (w_byte || r_state == IDLE || w_expire) r_tcount <= 20'd0;
            else                                       r_tcount <= r_tcount + 20'd1;

            if (w_byte) begin
                case (r_state)
                    GET_DEST:   r_dest <= bus.ipRxData;
                    GET_SOURCE: r_src  <= bus.ipRxData;
                    GET_LENGTH: begin
                        r_len       <= bus.ipRxData;
                        // Counter holds bytes left after the current one; Length 0 is 256 bytes.
                        r_remaining <= (bus.ipRxData == 8'd0) ? 9'd255 : {1'b0, bus.ipRxData} - 9'd1;
                        r_first     <= 1'b1;
                    end
                    GET_DATA: begin
                        r_valid     <= 1'b1;
                        r_data      <= bus.ipRxData;
                        r_sop       <= r_first;
                        r_eop       <= w_last;
                        r_first     <= 1'b0;
                        r_remaining <= r_remaining - 9'd1;
`ifndef CHECKSUM_EN
                        r_done      <= w_last;
`endif
                    end
`ifdef CHECKSUM_EN
                    GET_CHECKSUM: begin
                        r_done   <= (bus.ipRxData == r_sum);
                        r_cs_err <= (bus.ipRxData != r_sum);
                    end
`endif
                    default: ;
                endcase
`ifdef CHECKSUM_EN
                if (r_state == GET_DEST) r_sum <= bus.ipRxData;
                else if (r_state == GET_SOURCE || r_state == GET_LENGTH || r_state == GET_DATA)
                    r_sum <= r_sum + bus.ipRxData;
`endif
            end
        end
    end

    assign bus.opPacket = {r_src, r_dest, r_len, r_sop, r_eop, r_data, r_valid};
    assign opPacketDone = r_done;
    assign opTimeout    = r_timeout;
`ifdef CHECKSUM_EN
    assign opChecksumError = r_cs_err;
`else
    assign opChecksumError = 1'b0;
`endif
endmodule

// File: tb/tb_uart_packet_deframer.sv
// tb/tb_uart_packet_deframer.sv - directed vector bench for uart_packet_deframer (both CHECKSUM_EN builds)
module tb_uart_packet_deframer;
    localparam int T = 16;
`ifdef CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic ipClk = 1'b0;
    logic reset;
    logic opPacketDone, opTimeout, opChecksumError;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_packet_deframer_if bus ();

    uart_packet_deframer #(.SYNC_BYTE(8'h55), .TIMEOUT_CYCLES(T)) dut (
        .ipClk           (ipClk),
        .reset           (reset),
        .bus             (bus.slave),
        .opPacketDone    (opPacketDone),
        .opTimeout       (opTimeout),
        .opChecksumError (opChecksumError)
    );

    always #5 ipClk = ~ipClk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       ev;
        logic [7:0] ed;
        logic       sop;
        logic       eop;
        logic       done;
        logic       err;
        logic [7:0] dst;
        logic [7:0] src;
        logic [7:0] len;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void add(input logic v, input logic [7:0] d, input logic ev, input logic [7:0] ed,
                                input logic sop, input logic eop, input logic done, input logic err,
                                input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len);
        vec_t r;
        r.v = v; r.d = d; r.ev = ev; r.ed = ed; r.sop = sop; r.eop = eop;
        r.done = done; r.err = err; r.dst = dst; r.src = src; r.len = len;
        vq.push_back(r);
    endfunction

    function automatic void hdr(input logic [7:0] d);
        add(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endfunction

    function automatic void gap();
        add(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    endfunction

    function automatic void beat(input logic [7:0] d, input logic sop, input logic eop, input logic done,
                                 input logic [7:0] dst, input logic [7:0] src, input logic [7:0] len);
        add(1'b1, d, 1'b1, d, sop, eop, done, 1'b0, dst, src, len);
    endfunction

    function automatic void csum(input logic [7:0] d, input logic good);
        if (CK) add(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0, good, !good, 8'h00, 8'h00, 8'h00);
    endfunction

    task automatic run_vectors(input string tag);
        for (int i = 0; i < vq.size(); i++) begin
            bus.ipRxValid = vq[i].v;
            bus.ipRxData  = vq[i].d;
            @(posedge ipClk); #1;
            chk($sformatf("%s[%0d].valid", tag, i), 32'(bus.opPacket.Valid), 32'(vq[i].ev));
            chk($sformatf("%s[%0d].data", tag, i),  32'(bus.opPacket.Data),  32'(vq[i].ed));
            chk($sformatf("%s[%0d].sop", tag, i),   32'(bus.opPacket.SoP),   32'(vq[i].sop));
            chk($sformatf("%s[%0d].eop", tag, i),   32'(bus.opPacket.EoP),   32'(vq[i].eop));
            chk($sformatf("%s[%0d].done", tag, i),  32'(opPacketDone),       32'(vq[i].done));
            chk($sformatf("%s[%0d].cserr", tag, i), 32'(opChecksumError),    32'(vq[i].err));
            chk($sformatf("%s[%0d].tmo", tag, i),   32'(opTimeout),          32'd0);
            if (vq[i].ev) begin
                chk($sformatf("%s[%0d].dest", tag, i), 32'(bus.opPacket.Destination), 32'(vq[i].dst));
                chk($sformatf("%s[%0d].src", tag, i),  32'(bus.opPacket.Source),      32'(vq[i].src));
                chk($sformatf("%s[%0d].len", tag, i),  32'(bus.opPacket.Length),      32'(vq[i].len));
            end
        end
        bus.ipRxValid = 1'b0;
        bus.ipRxData  = 8'h00;
        vq.delete();
    endtask

    task automatic frame_short(input string tag);
        hdr(8'h55); hdr(8'h20); hdr(8'h03); hdr(8'h01);
        beat(8'h7E, 1'b1, 1'b1, !CK, 8'h20, 8'h03, 8'h01);
        csum(8'hA2, 1'b1);
        run_vectors(tag);
    endtask

    initial begin
        int n_to, to_at, n_bad;
        reset         = 1'b1;
        bus.ipRxValid = 1'b0;
        bus.ipRxData  = 8'h00;
        repeat (3) @(posedge ipClk);
        #1;
        chk("reset.valid", 32'(bus.opPacket.Valid), 32'd0);
        chk("reset.fields", 32'(bus.opPacket[34:1]), 32'd0);
        chk("reset.pulses", {29'd0, opPacketDone, opTimeout, opChecksumError}, 32'd0);
        reset = 1'b0;

        // Frames 1, 2 and 4 back to back, one idle gap inside frame 1.
        hdr(8'h55); hdr(8'h10); hdr(8'h01); hdr(8'h02);
        beat(8'hAA, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 8'h02);
        gap();
        beat(8'hBB, 1'b0, 1'b1, !CK, 8'h10, 8'h01, 8'h02);
        csum(8'h78, 1'b1);
        hdr(8'h00); hdr(8'h12);
        hdr(8'h55); hdr(8'h20); hdr(8'h03); hdr(8'h01);
        beat(8'h7E, 1'b1, 1'b1, !CK, 8'h20, 8'h03, 8'h01);
        csum(8'hA2, 1'b1);
        hdr(8'h55); hdr(8'h10); hdr(8'h01); hdr(8'h03);
        beat(8'h55, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 8'h03);
        beat(8'h55, 1'b0, 1'b0, 1'b0, 8'h10, 8'h01, 8'h03);
        beat(8'h55, 1'b0, 1'b1, !CK, 8'h10, 8'h01, 8'h03);
        csum(8'h13, 1'b1);
        gap();
        run_vectors("table");

        // Timeout mid-payload.
        hdr(8'h55); hdr(8'h10); hdr(8'h01); hdr(8'h04);
        beat(8'hAA, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 8'h04);
        run_vectors("tmo_pre");
        n_to = 0; to_at = -1; n_bad = 0;
        for (int k = 1; k <= 3 * T; k++) begin
            @(posedge ipClk); #1;
            if (opTimeout) begin
                n_to++;
                if (to_at < 0) to_at = k;
            end
            if (bus.opPacket.Valid || bus.opPacket.EoP || opPacketDone || opChecksumError) n_bad++;
        end
        chk("tmo.count", 32'(n_to), 32'd1);
        chk("tmo.cycle", 32'(to_at), 32'(T));
        chk("tmo.no_beats", 32'(n_bad), 32'd0);
        chk("tmo.dest_held", 32'(bus.opPacket.Destination), 32'h10);
        frame_short("tmo_post");

        // Reset after the second payload byte of a Length-4 frame.
        hdr(8'h55); hdr(8'h10); hdr(8'h01); hdr(8'h04);
        beat(8'hAA, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 8'h04);
        beat(8'hBB, 1'b0, 1'b0, 1'b0, 8'h10, 8'h01, 8'h04);
        run_vectors("rst_pre");
        reset = 1'b1;
        @(posedge ipClk); #1;
        reset = 1'b0;
        chk("rst.valid", 32'(bus.opPacket.Valid), 32'd0);
        chk("rst.dest", 32'(bus.opPacket.Destination), 32'd0);
        n_bad = 0;
        for (int k = 0; k < 2 * T; k++) begin
            @(posedge ipClk); #1;
            if (bus.opPacket.Valid || opPacketDone || opTimeout || opChecksumError) n_bad++;
        end
        chk("rst.quiet", 32'(n_bad), 32'd0);
        frame_short("rst_post");

        // Length 0 carries 256 payload bytes.
        hdr(8'h55); hdr(8'h01); hdr(8'h02); hdr(8'h00);
        for (int i = 0; i < 256; i++)
            beat(8'(i), i == 0, i == 255, (i == 255) && !CK, 8'h01, 8'h02, 8'h00);
        csum(8'h83, 1'b1);
        run_vectors("len256");

`ifdef CHECKSUM_EN
        hdr(8'h55); hdr(8'h10); hdr(8'h01); hdr(8'h02);
        beat(8'hAA, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 8'h02);
        beat(8'hBB, 1'b0, 1'b1, 1'b0, 8'h10, 8'h01, 8'h02);
        csum(8'h79, 1'b0);
        gap();
        run_vectors("cs_bad");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
